// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding,
// counter-width helper and the default 10 ms @ 100 MHz qualification count.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_t;

  localparam int CNT_MAX_100MHZ = 1_000_000;

  // Width needed to hold 0..cnt_max, never narrower than one bit.
  function automatic int cnt_width(input int cnt_max);
    int w;
    w = $clog2(cnt_max + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic STAGES-deep flip-flop synchroniser for asynchronous single-bit inputs.
// Every stage resets asynchronously (active-low) to RST_LEVEL.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RST_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw button level; clean only moves after the
// input has held a new level for CNT_MAX counts. Define DEBOUNCE_TICK_EN to count tick strobes.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   STABLE_LO | clean=0, sync agrees, idle
//   WAIT_HI   | sync went high, qualifying the rise (busy=1)
//   STABLE_HI | clean=1, sync agrees, idle
//   WAIT_LO   | sync went low, qualifying the fall (busy=1)
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int   CNT_MAX     = CNT_MAX_100MHZ,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
`ifdef DEBOUNCE_TICK_EN
  input  logic tick,
`endif
  output logic clean,
  output logic busy
);

  localparam int               CNT_W     = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam db_state_t        RST_STATE = RST_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync;
  logic             adv;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RST_LEVEL(RST_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (raw_in),
    .q  (sync)
  );

  // Counting and acceptance are gated by adv; bounce rejection is not.
`ifdef DEBOUNCE_TICK_EN
  assign adv = tick;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      clean <= RST_LEVEL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LO: begin
        cnt_nxt = '0;
        if (sync) state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (!sync) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (adv) begin
          if (cnt == CNT_LAST) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      STABLE_HI: begin
        cnt_nxt = '0;
        if (!sync) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (sync) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (adv) begin
          if (cnt == CNT_LAST) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = RST_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state == WAIT_HI) || (state == WAIT_LO);
    clean_nxt = clean;
    if ((state == WAIT_HI) && (state_nxt == STABLE_HI)) clean_nxt = 1'b1;
    if ((state == WAIT_LO) && (state_nxt == STABLE_LO)) clean_nxt = 1'b0;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (CNT_MAX=4, SYNC_STAGES=2, RST_LEVEL=0)
// against a run-length reference model; tick strobes used when DEBOUNCE_TICK_EN is defined.
module tb_button_debouncer;

  localparam int   CNT_MAX     = 4;
  localparam int   SYNC_STAGES = 2;
  localparam logic RST_LEVEL   = 1'b0;

  logic clk;
  logic rst;
  logic raw_in;
  logic clean;
  logic busy;
  logic tick_v;
`ifdef DEBOUNCE_TICK_EN
  logic tick;
  assign tick = tick_v;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: raw samples still travelling through the synchroniser,
  // the accepted level, and how long a disagreeing level has been held.
  logic hist[$];
  logic m_clean;
  logic m_wait;
  int   m_ticks;

  button_debouncer #(
    .CNT_MAX    (CNT_MAX),
    .SYNC_STAGES(SYNC_STAGES),
    .RST_LEVEL  (RST_LEVEL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_in(raw_in),
`ifdef DEBOUNCE_TICK_EN
    .tick  (tick),
`endif
    .clean (clean),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(RST_LEVEL);
    m_clean = RST_LEVEL;
    m_wait  = 1'b0;
    m_ticks = 0;
  endtask

  // The FSM acts on the raw level sampled SYNC_STAGES edges earlier.
  task automatic model_edge();
    logic seen;
    if (!rst) begin
      model_reset();
    end else begin
      seen = hist.pop_front();
      hist.push_back(raw_in);
      if (seen == m_clean) begin
        m_wait  = 1'b0;
        m_ticks = 0;
      end else if (!m_wait) begin
        m_wait  = 1'b1;
        m_ticks = 0;
      end else if (tick_v) begin
        m_ticks++;
        if (m_ticks == CNT_MAX) begin
          m_clean = seen;
          m_wait  = 1'b0;
          m_ticks = 0;
        end
      end
    end
  endtask

  task automatic step(input logic val, input logic rst_v);
    @(negedge clk);
    raw_in = val;
    rst    = rst_v;
    cyc++;
`ifdef DEBOUNCE_TICK_EN
    tick_v = (cyc % 5 == 0);
`endif
    @(posedge clk);
    model_edge();
    #1;
    check_bit("clean", clean, m_clean);
    check_bit("busy", busy, m_wait);
  endtask

  initial begin
    tick_v = 1'b1;
    raw_in = 1'b1;
    rst    = 1'b0;
    model_reset();
    #1;
    check_bit("rst_assert_clean", clean, 1'b0);
    check_bit("rst_assert_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Release with raw_in already high: full qualification from release.
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b1);
`ifndef DEBOUNCE_TICK_EN
      if (e == 6) check_bit("rel_e6_clean", clean, 1'b0);
      if (e == 7) check_bit("rel_e7_clean", clean, 1'b1);
`endif
    end

    // Falling step.
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1);
`ifndef DEBOUNCE_TICK_EN
      if (e == 2) check_bit("fall_e2_busy", busy, 1'b0);
      if (e >= 3 && e <= 6) check_bit("fall_busy", busy, 1'b1);
      if (e == 6) check_bit("fall_e6_clean", clean, 1'b1);
      if (e == 7) check_bit("fall_e7_clean", clean, 1'b0);
      if (e == 7) check_bit("fall_e7_busy", busy, 1'b0);
`endif
    end

    // Rising step.
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b1);
`ifndef DEBOUNCE_TICK_EN
      if (e >= 3 && e <= 6) check_bit("rise_busy", busy, 1'b1);
      if (e == 6) check_bit("rise_e6_clean", clean, 1'b0);
      if (e == 7) check_bit("rise_e7_clean", clean, 1'b1);
      if (e == 7) check_bit("rise_e7_busy", busy, 1'b0);
`endif
    end
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b1);

    // Bounce 1,0,1,0 every two cycles, then settle high.
    for (int b = 0; b < 8; b++) begin
      step(((b / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      check_bit("bounce_clean", clean, 1'b0);
    end
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b1);
`ifndef DEBOUNCE_TICK_EN
      if (e == 6) check_bit("settle_e6_clean", clean, 1'b0);
      if (e == 7) check_bit("settle_e7_clean", clean, 1'b1);
`endif
    end
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b1);

    // Glitch reaching sync on the cycle cnt==CNT_MAX-1.
    for (int e = 1; e <= 14; e++) begin
      step((e == 5) ? 1'b0 : 1'b1, 1'b1);
`ifndef DEBOUNCE_TICK_EN
      if (e == 6) check_bit("glitch_e6_busy", busy, 1'b1);
      if (e == 7) check_bit("glitch_e7_clean", clean, 1'b0);
      if (e == 7) check_bit("glitch_e7_busy", busy, 1'b0);
      if (e == 11) check_bit("glitch_e11_clean", clean, 1'b0);
      if (e == 12) check_bit("glitch_e12_clean", clean, 1'b1);
`endif
    end
    for (int e = 1; e <= 10; e++) step(1'b0, 1'b1);

    // Reset asserted mid-qualification (busy with cnt==2).
    for (int e = 1; e <= 5; e++) step(1'b1, 1'b1);
`ifndef DEBOUNCE_TICK_EN
    check_bit("midrst_pre_busy", busy, 1'b1);
`endif
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_bit("midrst_clean", clean, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b1);
`ifndef DEBOUNCE_TICK_EN
      if (e == 6) check_bit("midrst_e6_clean", clean, 1'b0);
      if (e == 7) check_bit("midrst_e7_clean", clean, 1'b1);
`endif
    end

    // Random hold lengths, mixing bounces shorter and longer than CNT_MAX.
    begin
      logic lvl;
      lvl = 1'b1;
      for (int seg = 0; seg < 120; seg++) begin
        int len;
        lvl = ~lvl;
        len = (seg % 4 == 3) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 8));
        for (int k = 0; k < len; k++) step(lvl, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the board's rising-edge pulse detector.
- Takes a raw, asynchronous, bouncing push-button/switch level and synchronises it into `clk`.
- Filters bounce and drives a clean, glitch-free level (`clean`) suitable as that detector's sampling input.
- Accepts a new level only after the input has been continuously stable for a programmable number of counts.

Parameters:
- CNT_MAX, 1000000, number of consecutive stable counts required to accept a new level (10 ms at 100 MHz); legal range ≥1.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; legal range ≥2.
- RST_LEVEL, 1'b0, level that the synchroniser chain and `clean` take during reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, release synchronous to clk.
- raw_in  input  1  raw asynchronous button/switch level.
- clean  output  1  debounced level; feeds the edge detector's sample input.
- busy  output  1  high while a candidate level change is being qualified (state WAIT_*).

Behaviour:
- Reset (rst=0), immediately:
  - synchroniser chain = RST_LEVEL; state = STABLE_<RST_LEVEL>; cnt = 0; clean = RST_LEVEL; busy = 0.
- Synchroniser: raw_in passes through SYNC_STAGES flops; `sync` is the last stage. No other logic samples raw_in.
- Counter: cnt width = clog2(CNT_MAX+1); never exceeds CNT_MAX-1; no wrap.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO:
  - sync=1 → WAIT_HI, cnt <= 0.
  - else hold.
- WAIT_HI:
  - sync=0 → STABLE_LO, cnt <= 0 (bounce rejected; clean never changed).
  - sync=1 and cnt==CNT_MAX-1 → STABLE_HI, clean <= 1.
  - sync=1 otherwise → cnt <= cnt+1.
- STABLE_HI / WAIT_LO: mirror image of the above.
- Outputs:
  - clean is registered and changes only on a WAIT→STABLE transition.
  - busy is high exactly in WAIT_HI/WAIT_LO.
- Latency: a clean step on raw_in (change between edges 0 and 1) updates clean at rising edge SYNC_STAGES+1+CNT_MAX.
  - Example: SYNC_STAGES=2, CNT_MAX=4 → edge 7.
- Boundary conditions:
  - Bounce on the very cycle cnt==CNT_MAX-1 (sync reverted) → rejected; returns to STABLE_<old>.
  - CNT_MAX=1 → one stable cycle in WAIT suffices.
  - rst asserted mid-WAIT → immediate return to reset values; no partial acceptance on release.
  - A pulse on raw_in shorter than one clk period may be missed entirely; this is acceptable.

Optional Feature:
- Macro: DEBOUNCE_TICK_EN.
- Defined:
  - Adds input port `tick` (1 bit, single-cycle strobe, e.g. 1 kHz).
  - In WAIT_*, cnt increments and the accept condition (cnt==CNT_MAX-1) is evaluated only on cycles with tick=1.
  - Bounce rejection (sync reverting) acts on every clk cycle regardless of tick.
  - CNT_MAX then counts ticks; default usage is CNT_MAX=10.
- Undefined: no tick port; counter advances every clk cycle as specified above.

Decomposition:
- Shared package `debounce_pkg`:
  - state encoding constants: STABLE_LO=2'b00, WAIT_HI=2'b01, STABLE_HI=2'b10, WAIT_LO=2'b11.
  - counter-width helper function (clog2).
  - default CNT_MAX constant for 100 MHz.
- One sub-module: `sync_ff`, a parameterised SYNC_STAGES-deep synchroniser with async active-low reset to RST_LEVEL.
  - Reused elsewhere for other asynchronous inputs.

Test Plan:
- Bench parameters: CNT_MAX=4, SYNC_STAGES=2, RST_LEVEL=0.
- Reset:
  - Stimulus: hold rst=0 with raw_in=1.
  - Required: clean=0, busy=0 throughout and immediately on assertion.
  - After release: clean rises at edge 7 after release.
- Clean step:
  - Stimulus: raw_in 0→1 between edges 0 and 1.
  - Required: busy=1 from edge 3 through edge 6; clean=1 and busy=0 at edge 7.
  - Reverse: symmetric 1→0 step yields clean=0 seven edges later.
- Bounce:
  - Stimulus: raw_in toggles 1,0,1,0 every 2 cycles, then settles at 1.
  - Required: clean stays 0 throughout bouncing; clean rises exactly 7 edges after the final settle.
- Late glitch:
  - Stimulus: raw_in=1 long enough for sync to reach cnt==3, then a 1-cycle 0 glitch on sync.
  - Required: state returns to STABLE_LO; clean remains 0; a full 4-cycle requalification is needed.
- Mid-operation reset:
  - Stimulus: assert rst=0 while busy=1 (cnt==2).
  - Required: busy=0, clean=0 combinationally; no clean pulse after release until a full requalification.
- Tick mode (DEBOUNCE_TICK_EN):
  - Stimulus: tick every 5 cycles, raw_in step to 1.
  - Required: clean rises on the 4th tick edge counted after entering WAIT_HI.
  - Stimulus: a sync glitch between ticks.
  - Required: still rejected.
